// File: rtl/lnvd_pkg.sv
// lnvd_pkg: shared widths, parameter limits and the tick-divider helper
// for the LNVD signal-capture conditioning stage.
package lnvd_pkg;

  localparam int LNVD_DW  = 8;
  localparam int LNVD_OW  = 12;
  localparam int LNVD_NCH = 4;

  localparam int LNVD_LOG2_AVG_MIN = 4;
  localparam int LNVD_LOG2_AVG_MAX = 8;

  typedef logic [LNVD_DW-1:0] lnvd_byte_t;
  typedef logic [LNVD_OW-1:0] lnvd_avg_t;

  function automatic int lnvd_div(input int clk_hz,
                                  input int sample_hz);
    return (sample_hz > 0) ? clk_hz / sample_hz : 0;
  endfunction

endpackage

// File: rtl/lnvd_chan_avg.sv
// lnvd_chan_avg: one channel's box-car accumulator, peak-hold and
// average output register.
// Ports: clk, rst (sync, active high), tick_i (sample strobe),
//   win_end_i (this tick closes the window), freeze_i, peak_clr_i,
//   data_i (raw byte), avg_o (12-bit mean x16), peak_o (max byte).
module lnvd_chan_avg
  import lnvd_pkg::*;
#(
  parameter int LOG2_AVG = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             win_end_i,
  input  logic             freeze_i,
  input  logic             peak_clr_i,
  input  lnvd_byte_t       data_i,
  output lnvd_avg_t        avg_o,
  output lnvd_byte_t       peak_o
);

  localparam int AW = LNVD_DW + LOG2_AVG;

  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] sum;
  lnvd_avg_t     avg_q, avg_d;
  lnvd_byte_t    peak_q, peak_d;

  assign sum = acc_q + AW'(data_i);

  always_comb begin
    acc_d  = acc_q;
    avg_d  = avg_q;
    peak_d = peak_q;
    if (tick_i) begin
      acc_d = win_end_i ? '0 : sum;
      // Top 12 bits of the sum == sum >> (LOG2_AVG-4).
      if (win_end_i && !freeze_i)
        avg_d = sum[AW-1 -: LNVD_OW];
      // A clear coinciding with a tick restarts from this sample.
      if (peak_clr_i || (data_i > peak_q))
        peak_d = data_i;
    end else if (peak_clr_i) begin
      peak_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      avg_q  <= '0;
      peak_q <= '0;
    end else begin
      acc_q  <= acc_d;
      avg_q  <= avg_d;
      peak_q <= peak_d;
    end
  end

  assign avg_o  = avg_q;
  assign peak_o = peak_q;

endmodule

// File: rtl/lnvd_sig_capture.sv
// lnvd_sig_capture: samples four byte channels at SAMPLE_HZ, averages
// 2^LOG2_AVG samples each and holds per-channel peaks for the viewer.
// Ports: clk, rst (sync, active high), ch_a..ch_d (raw bytes), freeze
//   (hold averages), peak_clr (clear peaks), avg_a..avg_d (12-bit
//   mean x16), peak_a..peak_d, upd (averages changed), tick (strobe).
module lnvd_sig_capture
  import lnvd_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SAMPLE_HZ = 1_000,
  parameter int LOG2_AVG  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ch_a,
  input  logic [7:0]  ch_b,
  input  logic [7:0]  ch_c,
  input  logic [7:0]  ch_d,
  input  logic        freeze,
  input  logic        peak_clr,
  output logic [11:0] avg_a,
  output logic [11:0] avg_b,
  output logic [11:0] avg_c,
  output logic [11:0] avg_d,
  output logic [7:0]  peak_a,
  output logic [7:0]  peak_b,
  output logic [7:0]  peak_c,
  output logic [7:0]  peak_d,
  output logic        upd,
  output logic        tick
);

  localparam int DIV = lnvd_div(CLK_HZ, SAMPLE_HZ);
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 2 ||
      LOG2_AVG < LNVD_LOG2_AVG_MIN ||
      LOG2_AVG > LNVD_LOG2_AVG_MAX) begin : g_bad_param
    $error("lnvd_sig_capture: illegal DIV or LOG2_AVG");
  end

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [LOG2_AVG-1:0] n_q, n_d;
  logic                upd_q, upd_d;
  logic                tick_w;
  logic                win_end;

  assign tick_w  = (cnt_q == CW'(DIV - 1));
  assign win_end = &n_q;

  always_comb begin
    cnt_d = tick_w ? '0 : cnt_q + 1'b1;
    n_d   = tick_w ? n_q + 1'b1 : n_q;
    upd_d = tick_w && win_end && !freeze;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      n_q   <= '0;
      upd_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      n_q   <= n_d;
      upd_q <= upd_d;
    end
  end

  lnvd_byte_t [LNVD_NCH-1:0] ch_w;
  lnvd_avg_t  [LNVD_NCH-1:0] avg_w;
  lnvd_byte_t [LNVD_NCH-1:0] peak_w;

  assign ch_w = {ch_d, ch_c, ch_b, ch_a};

  for (genvar g = 0; g < LNVD_NCH; g++) begin : g_ch
    lnvd_chan_avg #(
      .LOG2_AVG (LOG2_AVG)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .tick_i     (tick_w),
      .win_end_i  (win_end),
      .freeze_i   (freeze),
      .peak_clr_i (peak_clr),
      .data_i     (ch_w[g]),
      .avg_o      (avg_w[g]),
      .peak_o     (peak_w[g])
    );
  end

  assign {avg_d, avg_c, avg_b, avg_a}     = avg_w;
  assign {peak_d, peak_c, peak_b, peak_a} = peak_w;
  assign upd  = upd_q;
  assign tick = tick_w;

endmodule

// File: doc/lnvd_sig_capture.md
Name: lnvd_sig_capture

Overview:
- Conditioning stage between the LNVD_Firmware 4-channel byte outputs and the 4-signal hex viewer.
- Samples four 8-bit channels at a fixed tick rate and box-car averages 2^LOG2_AVG samples per channel.
- Presents 12-bit scaled averages (mean x16, 4 fractional bits) and per-channel peak-hold bytes, so the 7-segment readout is stable and readable instead of flickering raw GPIO.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- SAMPLE_HZ, 1_000, sample tick rate. DIV = CLK_HZ/SAMPLE_HZ, must be >= 2.
- LOG2_AVG, 4, log2 of samples per average. Legal range 4..8.

Ports:
- clk  in  1  50 MHz system clock
- rst  in  1  synchronous active-high reset
- ch_a, ch_b, ch_c, ch_d  in  8 each  raw channel bytes (GPIO[7:0], [15:8], [23:16], [31:24])
- freeze  in  1  high = hold avg outputs; accumulation continues
- peak_clr  in  1  single-cycle request to clear all peak registers
- avg_a, avg_b, avg_c, avg_d  out  12 each  scaled average, equal to sum >> (LOG2_AVG-4)
- peak_a, peak_b, peak_c, peak_d  out  8 each  max sample since last clear/reset
- upd  out  1  one-cycle pulse when avg_* change
- tick  out  1  one-cycle sample strobe, exported for debug

Behaviour:
- Reset (rst=1 at a clk edge):
  - tick counter, sample index, accumulators, avg_*, peak_*, upd and tick all go to 0.
  - Reset mid-window discards the partial sum; the first average after release needs a full 2^LOG2_AVG samples.
- Tick generator:
  - cnt counts 0..DIV-1 and wraps.
  - tick=1 in the cycle where cnt==DIV-1, so exactly one tick per DIV clocks.
  - First tick occurs DIV cycles after rst deasserts.
- Sampling:
  - On a tick cycle, ch_* are captured into the accumulators directly. No extra input register; upstream is synchronous to clk.
  - acc width = 8+LOG2_AVG, so there is no overflow.
- Window:
  - Sample index n counts 0..2^LOG2_AVG-1.
  - On the tick with n==last, the result is (acc+sample)>>(LOG2_AVG-4). The accumulator reloads to 0 and n wraps to 0.
- Output update:
  - If freeze=0 on that tick, avg_* load the result at the same edge and upd pulses high in the following cycle (latency 1 clk from the final tick edge).
  - If freeze=1, avg_* hold, upd stays 0 and the result is discarded.
  - Releasing freeze takes effect at the next window end, not immediately.
- Peak hold:
  - On a tick, peak_x <= max(peak_x, ch_x).
  - peak_clr without a tick: peak_* <= 0.
  - peak_clr coincident with a tick: peak_x <= ch_x (clear, then sample).
  - freeze does not affect peak tracking.
- Boundary values:
  - All-0xFF input over a full window gives avg=0xFF0 for any LOG2_AVG, with no wrap.
  - All-0x00 gives 0x000.
- No backpressure: the consumer samples avg_* at will; upd is advisory.

Decomposition:
- Package lnvd_pkg:
  - LNVD_DW=8, LNVD_OW=12, LNVD_NCH=4.
  - LNVD_LOG2_AVG_MIN=4, LNVD_LOG2_AVG_MAX=8.
  - Function lnvd_div(clk_hz, sample_hz).
- Sub-module lnvd_chan_avg, instantiated 4x:
  - Holds one channel's accumulator, peak register and output register.
  - Inputs: tick, win_end, freeze, peak_clr, and the data byte.
- The top level owns the tick counter, sample index and upd.
- Parameter legality is checked with an elaboration-time assertion.

Test Plan:
- Tick timing (CLK_HZ=100, SAMPLE_HZ=10, DIV=10): release rst, count cycles -> tick pulses at cycles 10, 20, 30…, each exactly one clk wide.
- Constant average (LOG2_AVG=4): ch_a=0x80, ch_b=0xFF, ch_c=0x00, ch_d=0x01 for 16 ticks -> after the 16th tick avg_a=0x800, avg_b=0xFF0, avg_c=0x000, avg_d=0x010, and upd pulses exactly 1 clk after the update edge.
- Ramp with LOG2_AVG=6: ch_a = 0..63 over 64 ticks -> sum 2016, avg_a=2016>>2=0x1F8.
- Freeze: assert freeze before the 2nd window end with new data 0x40 -> avg_a stays 0x800 and no upd. Deassert freeze -> next window end gives avg_a=0x400 plus upd.
- Peak: drive ch_c 0x10, 0x90, 0x20 -> peak_c=0x90. peak_clr alone -> 0x00. peak_clr on a tick with ch_c=0x33 -> peak_c=0x33.
- Reset mid-window: rst after 7 of 16 ticks -> all outputs 0. Next upd occurs only after 16 further ticks, with avg computed from post-reset samples only.
